// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch controller
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  // Word fetches must sit on a 4-byte boundary.
  function automatic logic misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - SRAM-like req/addr_ok/data_ok instruction bus
interface if_fetch_ctrl_if #(
  parameter int AW = 32,
  parameter int IW = 32
);

  logic          inst_req;
  logic          inst_wr;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [IW-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_wr,
    output inst_size,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_wr,
    input  inst_size,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - one-word-per-PC fetch controller with flush discard and AdEL detection
module if_fetch_ctrl #(
  parameter int            AW       = 32,
  parameter int            IW       = 32,
  parameter logic [IW-1:0] NOP_WORD = IW'(if_pkg::NOP_WORD)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  pc_f,
  input  logic           flush_f,
  input  logic           stall_d,
  output logic           stall_f,
  if_fetch_ctrl_if.master sram,
  output logic [IW-1:0]  instr_f,
  output logic [AW-1:0]  pc_out_f,
  output logic           instr_valid_f,
  output logic           adel_f
);

  import if_pkg::*;

  fetch_state_t  state;
  logic          discard;
  logic          req_active;
  logic [IW-1:0] buf_instr;
  logic [AW-1:0] buf_pc;
  logic          buf_adel;

  logic pc_bad;
  logic issue;
  logic data_fresh;
  logic hold_show;

  assign pc_bad = misaligned(pc_f[1:0]);

  // A request already on the bus stays up until accepted, even if a flush
  // has since moved pc_f somewhere misaligned; the answer is discarded later.
  assign issue      = (state == REQ) && (req_active || !pc_bad);
  assign data_fresh = (state == WAIT) && sram.inst_data_ok && !discard && !flush_f;
  assign hold_show  = (state == HOLD) && !flush_f;

  assign sram.inst_req  = issue;
  assign sram.inst_wr   = 1'b0;
  assign sram.inst_size = SIZE_WORD;
  assign sram.inst_addr = pc_f;

  assign instr_valid_f = data_fresh || hold_show;
  assign instr_f       = data_fresh ? sram.inst_rdata :
                         hold_show  ? buf_instr       : NOP_WORD;
  assign pc_out_f      = hold_show ? buf_pc : pc_f;
  assign adel_f        = hold_show && buf_adel;
  assign stall_f       = !(instr_valid_f && !stall_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      discard    <= 1'b0;
      req_active <= 1'b0;
      buf_instr  <= NOP_WORD;
      buf_pc     <= '0;
      buf_adel   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush_f && pc_bad) begin
            state     <= HOLD;
            buf_instr <= NOP_WORD;
            buf_pc    <= pc_f;
            buf_adel  <= 1'b1;
          end else begin
            state <= REQ;
          end
        end

        REQ: begin
          if (issue) begin
            if (flush_f) begin
              discard <= 1'b1;
            end
            if (sram.inst_addr_ok) begin
              state      <= WAIT;
              req_active <= 1'b0;
            end else begin
              req_active <= 1'b1;
            end
          end else if (!flush_f) begin
            // Misaligned PC: report AdEL from the hold buffer, never touch the SRAM.
            state     <= HOLD;
            buf_instr <= NOP_WORD;
            buf_pc    <= pc_f;
            buf_adel  <= 1'b1;
          end
        end

        WAIT: begin
          if (sram.inst_data_ok) begin
            discard <= 1'b0;
            if (discard || flush_f) begin
              state <= REQ;
            end else if (stall_d) begin
              state     <= HOLD;
              buf_instr <= sram.inst_rdata;
              buf_pc    <= pc_f;
              buf_adel  <= 1'b0;
            end else begin
              state <= REQ;
            end
          end else if (flush_f) begin
            discard <= 1'b1;
          end
        end

        HOLD: begin
          if (flush_f || !stall_d) begin
            state <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - scoreboard bench: PC register + SRAM models around if_fetch_ctrl
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_f;
  logic        flush_f;
  logic        stall_d;
  logic        stall_f;
  logic [31:0] instr_f;
  logic [31:0] pc_out_f;
  logic        instr_valid_f;
  logic        adel_f;

  always #5 clk = ~clk;

  if_fetch_ctrl_if #(.AW(32), .IW(32)) bus ();

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_f          (pc_f),
    .flush_f       (flush_f),
    .stall_d       (stall_d),
    .stall_f       (stall_f),
    .sram          (bus),
    .instr_f       (instr_f),
    .pc_out_f      (pc_out_f),
    .instr_valid_f (instr_valid_f),
    .adel_f        (adel_f)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   handoffs = 0;
  int   cyc = 0;
  int   last_handoff = 0;

  int unsigned flush_pct, stall_pct, ok_pct, lat_min, lat_max;
  logic        force_flush;
  logic [31:0] force_target;
  logic [31:0] flush_target;
  logic        pending;
  int          cnt;
  logic [31:0] pend_addr;
  logic        s_req, s_ok, s_dok, s_stall_f, s_flush, s_valid;
  logic [31:0] s_addr;
  logic        any_req;

  // Memory image: every word is its address scrambled with a fixed key.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h83c8_bfaf;
  endfunction

  // What decode must eventually receive for a given fetch PC.
  function automatic exp_t expect_for(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.adel  = (pc[1:0] != 2'b00);
    e.instr = e.adel ? 32'h0000_0000 : mem_word(pc);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (flush_f) check("valid_on_flush", {31'd0, instr_valid_f}, 32'd0);
      else         check("stall_f_rule", {31'd0, stall_f}, {31'd0, !(instr_valid_f && !stall_d)});
      check("inst_wr", {31'd0, bus.inst_wr}, 32'd0);
      check("inst_size", {30'd0, bus.inst_size}, 32'd2);
      if (instr_valid_f && !flush_f && !stall_d) begin
        handoffs++;
        last_handoff = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spare_handoff: got pc %h with nothing expected", pc_out_f);
        end else begin
          mon_e = exp_q.pop_front();
          check("handoff_pc", pc_out_f, mon_e.pc);
          check("handoff_instr", instr_f, mon_e.instr);
          check("handoff_adel", {31'd0, adel_f}, {31'd0, mon_e.adel});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    s_req     = bus.inst_req;
    s_ok      = bus.inst_addr_ok;
    s_addr    = bus.inst_addr;
    s_dok     = bus.inst_data_ok;
    s_stall_f = stall_f;
    s_flush   = flush_f;
    s_valid   = instr_valid_f;
    @(posedge clk);
    #1;
    cyc++;
    if (s_dok) pending = 1'b0;
    if (s_req && s_ok) begin
      total++;
      if (pending) begin
        bad++;
        $display("FAIL second_outstanding: got accept at %h want none", s_addr);
      end
      pending   = 1'b1;
      pend_addr = s_addr;
      cnt       = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = $urandom;
    if (pending) begin
      if (cnt == 0) begin
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem_word(pend_addr);
      end else begin
        cnt--;
      end
    end
    bus.inst_addr_ok = ($urandom_range(99) < ok_pct);
    if (s_flush) begin
      pc_f = flush_target;
      exp_q.delete();
      exp_q.push_back(expect_for(pc_f));
    end else if (!s_stall_f) begin
      pc_f = pc_f + 32'd4;
      exp_q.push_back(expect_for(pc_f));
    end
    stall_d = ($urandom_range(99) < stall_pct);
    if (force_flush) begin
      flush_f      = 1'b1;
      flush_target = force_target;
      force_flush  = 1'b0;
    end else begin
      flush_f      = ($urandom_range(99) < flush_pct);
      flush_target = 32'hbfc0_0000 + (32'($urandom_range(255)) << 2)
                   + (($urandom_range(7) == 0) ? 32'($urandom_range(3)) : 32'd0);
    end
    if (cyc - last_handoff > 200) begin
      total++;
      bad++;
      $display("FAIL watchdog: got no handoff for %0d cycles want at most 200", cyc - last_handoff);
      last_handoff = cyc;
    end
  endtask

  task automatic set_mode(input int unsigned f, input int unsigned s, input int unsigned o,
                          input int unsigned lmin, input int unsigned lmax);
    flush_pct = f;
    stall_pct = s;
    ok_pct    = o;
    lat_min   = lmin;
    lat_max   = lmax;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.inst_addr_ok = 1'b1;
    exp_q.delete();
    exp_q.push_back(expect_for(pc_f));
    last_handoff = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_req"}, {31'd0, bus.inst_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid_f}, 32'd0);
    check({tag, "_instr"}, instr_f, 32'h0000_0000);
    check({tag, "_adel"}, {31'd0, adel_f}, 32'd0);
    check({tag, "_stall_f"}, {31'd0, stall_f}, 32'd1);
  endtask

  initial begin
    pc_f = 32'hbfc0_0000;
    flush_f = 1'b0;
    stall_d = 1'b0;
    flush_target = 32'hbfc0_0000;
    force_flush = 1'b0;
    force_target = 32'h0;
    pending = 1'b0;
    cnt = 0;
    pend_addr = 32'h0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata = 32'h0;
    set_mode(0, 0, 100, 2, 2);

    #12;
    check_reset_outputs("reset");

    // Reset release, addr_ok immediately, data two cycles after acceptance.
    release_reset();
    step(); check("idle_no_req", {31'd0, s_req}, 32'd0);
    step(); check("first_req", {31'd0, s_req}, 32'd1);
            check("first_addr", s_addr, 32'hbfc0_0000);
    step(); check("wait_stall_f", {31'd0, s_stall_f}, 32'd1);
    step(); check("first_valid", {31'd0, s_valid}, 32'd1);
            check("first_stall_f", {31'd0, s_stall_f}, 32'd0);
    stall_pct = 100;
    step(); check("next_stall_f", {31'd0, s_stall_f}, 32'd1);
            check("next_addr", s_addr, 32'hbfc0_0004);

    // Decode stalls: the instruction must park in HOLD with no new request.
    repeat (4) step();
    check("hold_valid", {31'd0, s_valid}, 32'd1);
    check("hold_stall_f", {31'd0, s_stall_f}, 32'd1);
    check("hold_no_req", {31'd0, s_req}, 32'd0);
    stall_pct = 0;
    step();
    step(); check("hold_release_stall_f", {31'd0, s_stall_f}, 32'd0);
    step(); check("after_hold_addr", s_addr, 32'hbfc0_0008);

    // Redirect to a misaligned PC: AdEL, and the SRAM never sees a request.
    force_target = 32'hbfc0_0002;
    force_flush  = 1'b1;
    repeat (3) step();
    any_req = 1'b0;
    repeat (10) begin
      step();
      any_req = any_req | s_req;
    end
    check("adel_no_req", {31'd0, any_req}, 32'd0);

    set_mode(8, 30, 60, 1, 4);   repeat (600) step();
    set_mode(20, 10, 100, 1, 1); repeat (600) step();
    set_mode(3, 50, 30, 1, 3);   repeat (600) step();
    set_mode(12, 0, 80, 2, 2);   repeat (400) step();

    // Asynchronous reset landing in WAIT while read data is on the bus.
    set_mode(0, 0, 100, 1, 1);
    begin
      int guard;
      guard = 0;
      while (!(pending && bus.inst_data_ok) && guard < 100) begin
        step();
        guard++;
      end
      check("reach_wait_guard", {31'd0, pending && bus.inst_data_ok}, 32'd1);
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    pending = 1'b0;
    bus.inst_data_ok = 1'b0;
    flush_f = 1'b0;
    stall_d = 1'b0;
    pc_f = 32'hbfc0_0100;
    release_reset();
    step(); check("reset_idle_no_req", {31'd0, s_req}, 32'd0);
    step(); check("reset_req", {31'd0, s_req}, 32'd1);
            check("reset_req_addr", s_addr, 32'hbfc0_0100);
    repeat (20) step();

    total++;
    if (handoffs < 100) begin
      bad++;
      $display("FAIL handoff_count: got %0d want at least 100", handoffs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller that sits directly downstream of the fetch PC register and drives the instruction SRAM through an SRAM-like req/addr_ok/data_ok interface.
- Issues one word fetch per PC and holds the PC register (via stall_f) until the instruction is handed to decode.
- Discards in-flight responses on flush and flags misaligned fetch addresses as AdEL instead of issuing them.

Parameters:
- AW, 32, fetch address width
- IW, 32, instruction width
- NOP_WORD, 32'h0000_0000, value driven on instr_f when no valid instruction or on AdEL

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- pc_f  in  AW  current fetch PC from the PC register
- flush_f  in  1  redirect; the PC register loads the new PC this same cycle
- stall_d  in  1  decode cannot accept an instruction this cycle
- stall_f  out  1  hold the PC register (PC register enable = ~stall_f)
- inst_req  out  1  SRAM request valid
- inst_wr  out  1  tied 0
- inst_size  out  2  tied 2'b10 (word)
- inst_addr  out  AW  request address = pc_f
- inst_addr_ok  in  1  address accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  IW  read data
- instr_f  out  IW  instruction to decode
- pc_out_f  out  AW  PC belonging to instr_f
- instr_valid_f  out  1  instr_f/pc_out_f/adel_f meaningful this cycle
- adel_f  out  1  fetch address error (pc_f[1:0] != 0)

Behaviour:
- Reset values: inst_req=0, instr_valid_f=0, instr_f=NOP_WORD, adel_f=0, stall_f=1, discard=0, state=IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: lasts one cycle after reset release.
  - If pc_f[1:0]!=0, go to HOLD with adel buffered; no request is issued.
  - Otherwise go to REQ.
- REQ: inst_req=1, inst_addr=pc_f.
  - The request is never withdrawn once asserted; pc_f must be stable, which is guaranteed by stall_f=1.
  - On inst_addr_ok, go to WAIT.
  - flush_f while in REQ sets discard. The accepted request (same or next cycle) is then treated as stale.
- WAIT: waits for inst_data_ok.
  - data_ok with discard=1: drop the data, clear discard, go to REQ (misaligned check applies to the new pc_f).
  - data_ok with discard=0 and flush_f=1 in the same cycle: drop the data, go to REQ.
  - data_ok, no discard, no flush: instr_f=inst_rdata combinationally (bypass), instr_valid_f=1.
    - stall_d=0: stall_f=0 and return to REQ next cycle for the next PC. Misaligned next PC goes to HOLD with adel.
    - stall_d=1: latch rdata into the hold buffer, go to HOLD.
  - flush_f without data_ok: set discard, stay in WAIT.
- HOLD: instr_valid_f=1 from the buffer, stall_f=1 until stall_d=0.
  - Then stall_f=0 and go to REQ next cycle.
  - flush_f in HOLD drops the buffer and goes to REQ; instr_valid_f=0 that cycle.
- stall_f is 0 only in a cycle where a non-discarded instruction (or AdEL) is presented with stall_d=0; otherwise it is 1.
  - On flush_f, stall_f is don't-care, because flush has priority in the PC register.
- flush_f always forces instr_valid_f=0 in that cycle.
- At most one outstanding SRAM transaction and one discard are pending at any time.
- AdEL entry: instr_f=NOP_WORD, adel_f=1, pc_out_f=faulting PC, no inst_req.
- Reset mid-operation: FSM returns to IDLE asynchronously and discard clears. The SRAM shares the reset, so no orphan response is expected.

Decomposition:
- Shared package if_pkg: fetch_state_t enum (IDLE, REQ, WAIT, HOLD), SIZE_WORD=2'b10, NOP_WORD.
- No sub-module. The hold buffer (instr, pc, adel) is three registers inside the block.

Test Plan:
- Reset release, pc_f=32'hbfc00000, addr_ok same cycle, data_ok 2 cycles later with rdata=32'h3c08bfaf -> instr_valid_f=1, instr_f=32'h3c08bfaf, pc_out_f=32'hbfc00000, stall_f=0 in that cycle only.
- Same fetch with stall_d=1 for 3 cycles -> HOLD; instr_f stays 32'h3c08bfaf, stall_f=1, inst_req=0; stall_d drops -> stall_f=0, then REQ for 32'hbfc00004.
- flush_f in WAIT, then data_ok with rdata=32'hdeadbeef -> no instr_valid_f; next inst_req carries new pc_f=32'hbfc00380; its data is delivered normally.
- flush_f in REQ before addr_ok (addr_ok arrives 1 cycle later) -> first response dropped, exactly one later response delivered, for the new PC.
- pc_f=32'hbfc00002 -> no inst_req, instr_valid_f=1, adel_f=1, instr_f=NOP_WORD, pc_out_f=32'hbfc00002.
- rst asserted low while in WAIT -> all outputs take their reset values immediately (asynchronous); after release, IDLE lasts one cycle, then REQ.
